// File: rtl/data_sram_bridge_pkg.sv
// Shared definitions for the core-side sram bridges.
// Contents: bridge FSM state encoding, access-size codes, kseg segment
// tags and a helper that recognises directly-mapped kernel segments.
package cpu_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_HOLD = 2'd3
    } bridge_state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [2:0] KSEG0_HI = 3'b100;
    localparam logic [2:0] KSEG1_HI = 3'b101;

    // True for kseg0/kseg1, the two segments translated by dropping the top bits.
    function automatic logic is_kseg01(input logic [31:0] vaddr);
        return (vaddr[31:29] == KSEG0_HI) || (vaddr[31:29] == KSEG1_HI);
    endfunction

endpackage

// File: rtl/data_sram_bridge_if.sv
// Split address/data sram-like bus between a bridge and the memory system.
// master (bridge): drives req/wr/size/addr/wdata, receives addr_ok/data_ok/rdata.
// slave (memory) : the mirror image.
interface data_sram_bridge_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/data_sram_bridge_kseg_addr_map.sv
// Virtual-to-physical address map shared by the instruction and data bridges.
// Ports: vaddr (in, 32) virtual byte address; paddr (out, 32) physical address.
// With MAP_KSEG != 0, kseg0/kseg1 lose their top three bits; everything
// else (and everything when MAP_KSEG == 0) passes through unchanged.
module kseg_addr_map
    import cpu_defs::*;
#(
    parameter int MAP_KSEG = 1
) (
    input  logic [31:0] vaddr,
    output logic [31:0] paddr
);

    // Purely combinational translation.
    always_comb begin
        paddr = vaddr;
        if ((MAP_KSEG != 32'sd0) && is_kseg01(vaddr)) begin
            paddr = {3'b000, vaddr[28:0]};
        end else begin
            paddr = vaddr;
        end
    end

endmodule

// File: rtl/data_sram_bridge.sv
// M-stage data port to split address/data sram-like bus bridge.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   cpu_en/wen/size/addr/wdata  M-stage access (wen != 0 means store)
//   cpu_rdata                load data (live on the data_ok cycle, buffered after)
//   cpu_stall                hold the pipeline while the access is outstanding
//   cpu_longest_stall        pipeline held by some other source
//   mem                      sram-like bus, master side
// The buffered load data lets the pipeline sit in other hazards after the
// access finished without the access being issued a second time.
module data_sram_bridge
    import cpu_defs::*;
#(
    parameter int MAP_KSEG = 1,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_wen,
    input  logic [1:0]        cpu_size,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              cpu_longest_stall,
    data_sram_bridge_if.master mem
);

    bridge_state_e     state_r;
    bridge_state_e     state_next_s;
    logic [DATA_W-1:0] rdata_buf_r;
    logic [31:0]       mem_addr_s;

    kseg_addr_map #(
        .MAP_KSEG(MAP_KSEG)
    ) u_kseg_addr_map (
        .vaddr(cpu_addr),
        .paddr(mem_addr_s)
    );

    // Request fields follow the core directly; the core holds them while stalled.
    assign mem.addr  = mem_addr_s;
    assign mem.wr    = |cpu_wen;
    assign mem.size  = cpu_size;
    assign mem.wdata = cpu_wdata;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; data_ok outside DATA is a protocol error and is ignored.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cpu_en) begin
                    if (mem.addr_ok) begin
                        state_next_s = ST_DATA;
                    end else begin
                        state_next_s = ST_ADDR;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (mem.addr_ok) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (mem.data_ok) begin
                    // Pipeline still held elsewhere: park so the same access is not re-issued.
                    if (cpu_longest_stall) begin
                        state_next_s = ST_HOLD;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_HOLD: begin
                if (cpu_longest_stall) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Load-data buffer, captured on every completion (store captures are don't-care).
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_buf_r <= {DATA_W{1'b0}};
        end else if ((state_r == ST_DATA) && mem.data_ok) begin
            rdata_buf_r <= mem.rdata;
        end else begin
            rdata_buf_r <= rdata_buf_r;
        end
    end

    // Outputs: request/stall decode, zero-wait bypass of data_ok into cpu_rdata.
    always_comb begin
        mem.req   = 1'b0;
        cpu_stall = 1'b0;
        cpu_rdata = rdata_buf_r;
        if (rst) begin
            mem.req   = 1'b0;
            cpu_stall = 1'b0;
            cpu_rdata = {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    mem.req   = cpu_en;
                    cpu_stall = cpu_en;
                end
                ST_ADDR: begin
                    mem.req   = 1'b1;
                    cpu_stall = 1'b1;
                end
                ST_DATA: begin
                    cpu_stall = ~mem.data_ok;
                    if (mem.data_ok) begin
                        cpu_rdata = mem.rdata;
                    end else begin
                        cpu_rdata = rdata_buf_r;
                    end
                end
                ST_HOLD: begin
                    mem.req   = 1'b0;
                    cpu_stall = 1'b0;
                end
                default: begin
                    mem.req   = 1'b0;
                    cpu_stall = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench for data_sram_bridge: a table of directed cycle
// vectors, randomized transactions checked against a transaction-timeline
// model, and a short sequence on a second instance built with MAP_KSEG = 0.
module tb_data_sram_bridge;

    typedef struct {
        logic        rst;
        logic        en;
        logic [3:0]  wen;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ls;
        logic        aok;
        logic        dok;
        logic [31:0] mrd;
        logic        e_req;
        logic        e_stall;
        logic [31:0] e_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, ls;
    logic [3:0]  wen;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    logic        stall;

    logic        en1, ls1;
    logic [3:0]  wen1;
    logic [1:0]  size1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        stall1;

    int checks  = 0;
    int errors  = 0;
    int req_cnt = 0;
    int exp_cnt = 0;
    int cyc     = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    data_sram_bridge_if bus0 ();
    data_sram_bridge_if bus1 ();

    data_sram_bridge #(.MAP_KSEG(1), .DATA_W(32)) u_dut (
        .clk(clk), .rst(rst), .cpu_en(en), .cpu_wen(wen), .cpu_size(size),
        .cpu_addr(addr), .cpu_wdata(wdata), .cpu_rdata(rdata), .cpu_stall(stall),
        .cpu_longest_stall(ls), .mem(bus0)
    );

    data_sram_bridge #(.MAP_KSEG(0), .DATA_W(32)) u_dut_nomap (
        .clk(clk), .rst(rst), .cpu_en(en1), .cpu_wen(wen1), .cpu_size(size1),
        .cpu_addr(addr1), .cpu_wdata(wdata1), .cpu_rdata(rdata1), .cpu_stall(stall1),
        .cpu_longest_stall(ls1), .mem(bus1)
    );

    // Count requests actually accepted by the memory side.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bus0.req && bus0.addr_ok) req_cnt <= req_cnt + 1;
    end

    function automatic logic [31:0] map_ref(input logic [31:0] a, input bit kseg);
        if (kseg && a >= 32'h8000_0000 && a < 32'hA000_0000) return a - 32'h8000_0000;
        if (kseg && a >= 32'hA000_0000 && a < 32'hC000_0000) return a - 32'hA000_0000;
        return a;
    endfunction

    function automatic vec_t mk(input logic r, input logic e, input logic [3:0] w,
                                input logic [1:0] s, input logic [31:0] a, input logic [31:0] wd,
                                input logic l, input logic ao, input logic dk, input logic [31:0] md,
                                input logic xr, input logic xs, input logic [31:0] xd);
        vec_t v;
        v.rst = r; v.en = e; v.wen = w; v.size = s; v.addr = a; v.wdata = wd;
        v.ls = l; v.aok = ao; v.dok = dk; v.mrd = md;
        v.e_req = xr; v.e_stall = xs; v.e_rdata = xd;
        return v;
    endfunction

    task automatic add(input logic r, input logic e, input logic [3:0] w,
                       input logic [1:0] s, input logic [31:0] a, input logic [31:0] wd,
                       input logic l, input logic ao, input logic dk, input logic [31:0] md,
                       input logic xr, input logic xs, input logic [31:0] xd);
        vecs.push_back(mk(r, e, w, s, a, wd, l, ao, dk, md, xr, xs, xd));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Apply one cycle of stimulus on the falling edge and check before the rising edge.
    task automatic step(input vec_t v);
        @(negedge clk);
        rst   = v.rst;  en = v.en;  wen = v.wen;  size = v.size;
        addr  = v.addr; wdata = v.wdata; ls = v.ls;
        bus0.addr_ok = v.aok; bus0.data_ok = v.dok; bus0.rdata = v.mrd;
        #2;
        chk("mem_req",   {31'd0, bus0.req}, {31'd0, v.e_req});
        chk("cpu_stall", {31'd0, stall},    {31'd0, v.e_stall});
        chk("cpu_rdata", rdata,             v.e_rdata);
        chk("mem_wr",    {31'd0, bus0.wr},  {31'd0, (v.wen != 4'd0)});
        chk("mem_addr",  bus0.addr,         map_ref(v.addr, 1'b1));
        chk("mem_size",  {30'd0, bus0.size}, {30'd0, v.size});
        chk("mem_wdata", bus0.wdata,        v.wdata);
        if (!v.rst && v.e_req && v.aok) exp_cnt++;
    endtask

    initial begin
        int a_d, d_d, h_d, g_d;
        logic [31:0] buf_m, ta, td, trd;
        logic [3:0]  tw;
        logic [1:0]  ts;
        logic        is_st;

        rst = 1'b1; en = 1'b0; wen = 4'd0; size = 2'd0; addr = 32'd0; wdata = 32'd0; ls = 1'b0;
        bus0.addr_ok = 1'b0; bus0.data_ok = 1'b0; bus0.rdata = 32'd0;
        en1 = 1'b0; wen1 = 4'd0; size1 = 2'd2; addr1 = 32'd0; wdata1 = 32'd0; ls1 = 1'b0;
        bus1.addr_ok = 1'b0; bus1.data_ok = 1'b0; bus1.rdata = 32'd0;

        // Reset, including reset dominating a live request.
        add(1, 0, 4'h0, 2, 32'h0,         32'h0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        add(1, 1, 4'h0, 2, 32'hBFC0_0010, 32'h0, 0, 1, 0, 32'h0, 0, 0, 32'h0);
        // Zero-wait word load from kseg1.
        add(0, 1, 4'h0, 2, 32'hBFC0_0010, 32'h0, 0, 1, 0, 32'h0,         1, 1, 32'h0);
        add(0, 1, 4'h0, 2, 32'hBFC0_0010, 32'h0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF);
        add(0, 0, 4'h0, 2, 32'hBFC0_0010, 32'h0, 0, 0, 0, 32'h0,         0, 0, 32'hDEAD_BEEF);
        // Byte store with addr_ok three cycles late.
        add(0, 1, 4'h4, 0, 32'h8000_0002, 32'h00AB_0000, 0, 0, 0, 32'h0, 1, 1, 32'hDEAD_BEEF);
        add(0, 1, 4'h4, 0, 32'h8000_0002, 32'h00AB_0000, 0, 0, 0, 32'h0, 1, 1, 32'hDEAD_BEEF);
        add(0, 1, 4'h4, 0, 32'h8000_0002, 32'h00AB_0000, 0, 0, 0, 32'h0, 1, 1, 32'hDEAD_BEEF);
        add(0, 1, 4'h4, 0, 32'h8000_0002, 32'h00AB_0000, 0, 1, 0, 32'h0, 1, 1, 32'hDEAD_BEEF);
        add(0, 1, 4'h4, 0, 32'h8000_0002, 32'h00AB_0000, 0, 0, 1, 32'h1234_5678, 0, 0, 32'h1234_5678);
        add(0, 0, 4'h0, 0, 32'h0,         32'h0,         0, 0, 0, 32'h0,         0, 0, 32'h1234_5678);
        // Load finishing while the pipeline is held four more cycles (stray data_ok included).
        add(0, 1, 4'h0, 2, 32'h0000_1000, 32'h0, 0, 1, 0, 32'h0,         1, 1, 32'h1234_5678);
        add(0, 1, 4'h0, 2, 32'h0000_1000, 32'h0, 1, 0, 1, 32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D);
        add(0, 1, 4'h0, 2, 32'h0000_1000, 32'h0, 1, 0, 0, 32'h0,         0, 0, 32'hCAFE_F00D);
        add(0, 1, 4'h0, 2, 32'h0000_1000, 32'h0, 1, 0, 1, 32'hBAD0_BAD0, 0, 0, 32'hCAFE_F00D);
        add(0, 1, 4'h0, 2, 32'h0000_1000, 32'h0, 1, 0, 0, 32'h0,         0, 0, 32'hCAFE_F00D);
        add(0, 1, 4'h0, 2, 32'h0000_1000, 32'h0, 1, 0, 0, 32'h0,         0, 0, 32'hCAFE_F00D);
        add(0, 1, 4'h0, 2, 32'h0000_1000, 32'h0, 0, 0, 0, 32'h0,         0, 0, 32'hCAFE_F00D);
        add(0, 0, 4'h0, 2, 32'h0000_1000, 32'h0, 0, 0, 0, 32'h0,         0, 0, 32'hCAFE_F00D);
        // Two back-to-back loads.
        add(0, 1, 4'h0, 2, 32'h8000_0100, 32'h0, 0, 1, 0, 32'h0,         1, 1, 32'hCAFE_F00D);
        add(0, 1, 4'h0, 2, 32'h8000_0100, 32'h0, 0, 0, 1, 32'h1111_1111, 0, 0, 32'h1111_1111);
        add(0, 1, 4'h0, 2, 32'h8000_0104, 32'h0, 0, 1, 0, 32'h0,         1, 1, 32'h1111_1111);
        add(0, 1, 4'h0, 2, 32'h8000_0104, 32'h0, 0, 0, 1, 32'h2222_2222, 0, 0, 32'h2222_2222);
        add(0, 0, 4'h0, 2, 32'h0,         32'h0, 0, 0, 0, 32'h0,         0, 0, 32'h2222_2222);
        // Reset while waiting for data, then a normal load.
        add(0, 1, 4'h0, 2, 32'h8000_0200, 32'h0, 0, 1, 0, 32'h0,         1, 1, 32'h2222_2222);
        add(0, 1, 4'h0, 2, 32'h8000_0200, 32'h0, 0, 0, 0, 32'h0,         0, 1, 32'h2222_2222);
        add(1, 1, 4'h0, 2, 32'h8000_0200, 32'h0, 0, 0, 0, 32'h0,         0, 0, 32'h0);
        add(0, 0, 4'h0, 2, 32'h8000_0200, 32'h0, 0, 0, 0, 32'h0,         0, 0, 32'h0);
        add(0, 1, 4'h0, 2, 32'h0000_0300, 32'h0, 0, 0, 0, 32'h0,         1, 1, 32'h0);
        add(0, 1, 4'h0, 2, 32'h0000_0300, 32'h0, 0, 1, 0, 32'h0,         1, 1, 32'h0);
        add(0, 1, 4'h0, 2, 32'h0000_0300, 32'h0, 0, 0, 1, 32'h3333_3333, 0, 0, 32'h3333_3333);
        // Stray data_ok in IDLE is ignored.
        add(0, 0, 4'h0, 0, 32'h0,         32'h0, 0, 0, 1, 32'hBAD0_0BAD, 0, 0, 32'h3333_3333);
        add(0, 1, 4'h0, 2, 32'h0000_0400, 32'h0, 0, 1, 0, 32'h0,         1, 1, 32'h3333_3333);
        add(0, 1, 4'h0, 2, 32'h0000_0400, 32'h0, 0, 0, 1, 32'h4444_4444, 0, 0, 32'h4444_4444);
        add(0, 0, 4'h0, 2, 32'h0,         32'h0, 0, 0, 0, 32'h0,         0, 0, 32'h4444_4444);

        foreach (vecs[i]) step(vecs[i]);
        chk("req_count_directed", req_cnt, exp_cnt);

        // MAP_KSEG = 0 instance: kseg1 address passes unchanged.
        @(negedge clk);
        en1 = 1'b1; addr1 = 32'hA000_0000; bus1.addr_ok = 1'b1;
        #2;
        chk("nomap_addr", bus1.addr, 32'hA000_0000);
        chk("nomap_req", {31'd0, bus1.req}, 32'd1);
        @(negedge clk);
        bus1.addr_ok = 1'b0; bus1.data_ok = 1'b1; bus1.rdata = 32'h5A5A_5A5A;
        #2;
        chk("nomap_rdata", rdata1, 32'h5A5A_5A5A);
        chk("nomap_stall", {31'd0, stall1}, 32'd0);
        @(negedge clk);
        en1 = 1'b0; bus1.data_ok = 1'b0; addr1 = 32'h8000_0004;
        #2;
        chk("nomap_addr2", bus1.addr, 32'h8000_0004);
        chk("nomap_buf", rdata1, 32'h5A5A_5A5A);

        // Randomized transactions against a timeline model.
        step(mk(1, 0, 4'h0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 32'h0));
        buf_m = 32'h0;
        for (int t = 0; t < 150; t++) begin
            a_d = $urandom_range(0, 3); d_d = $urandom_range(0, 3);
            h_d = $urandom_range(0, 3); g_d = $urandom_range(0, 2);
            is_st = 1'($urandom_range(0, 1));
            tw  = is_st ? 4'($urandom_range(1, 15)) : 4'h0;
            ts  = 2'($urandom_range(0, 2));
            case ($urandom_range(0, 3))
                0:       ta = {3'b000, 29'($urandom)};
                1:       ta = {3'b100, 29'($urandom)};
                2:       ta = {3'b101, 29'($urandom)};
                default: ta = {3'b110, 29'($urandom)};
            endcase
            td  = $urandom; trd = $urandom;
            // Request phase: held until addr_ok on its last cycle.
            for (int k = 0; k <= a_d; k++)
                step(mk(0, 1, tw, ts, ta, td, 1'($urandom_range(0, 1)), (k == a_d),
                        (k != a_d) && ($urandom_range(0, 3) == 0), $urandom, 1, 1, buf_m));
            // Waiting for data.
            for (int k = 0; k < d_d; k++)
                step(mk(0, 1, tw, ts, ta, td, 1'($urandom_range(0, 1)), 0, 0, $urandom, 0, 1, buf_m));
            // Completion; pipeline held elsewhere when h_d > 0.
            step(mk(0, 1, tw, ts, ta, td, (h_d > 0), 0, 1, trd, 0, 0, trd));
            buf_m = trd;
            for (int k = 1; k <= h_d; k++)
                step(mk(0, 1, tw, ts, ta, td, (k < h_d), 0, ($urandom_range(0, 3) == 0),
                        $urandom, 0, 0, buf_m));
            for (int k = 0; k < g_d; k++)
                step(mk(0, 0, 4'($urandom), 2'($urandom_range(0, 2)), $urandom, $urandom,
                        1'($urandom_range(0, 1)), 0, ($urandom_range(0, 3) == 0),
                        $urandom, 0, 0, buf_m));
        end
        step(mk(0, 0, 4'h0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 0, buf_m));
        chk("req_count_random", req_cnt, exp_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_sram_bridge.md
Name: data_sram_bridge

Overview:
- Sits directly downstream of the core's M-stage data port (byte-enable store, address, write data, read data).
- Converts the core's single-cycle memory view into a split address/data sram-like handshake towards the memory system.
- Raises a stall to the pipeline while a transaction is outstanding.
- Buffers completed load data while the pipeline is held by other hazards, so no request is ever issued twice.

Parameters:
- MAP_KSEG, 1: when 1, kseg0/kseg1 virtual addresses (addr[31:29] = 3'b100 or 3'b101) map to physical by clearing addr[31:29]; when 0, addresses pass unchanged.
- DATA_W, 32: data width; only 32 is supported.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- cpu_en  in  1  M-stage memory access valid (load or store)
- cpu_wen  in  4  byte enables; nonzero = store, 0 = load
- cpu_size  in  2  0 = byte, 1 = half, 2 = word
- cpu_addr  in  32  virtual byte address
- cpu_wdata  in  32  store data, already lane-aligned
- cpu_rdata  out  32  load data to M/W stage
- cpu_stall  out  1  hold the pipeline
- cpu_longest_stall  in  1  pipeline held by any source other than this block
- mem_req  out  1  request valid
- mem_wr  out  1  1 = write
- mem_size  out  2  copy of cpu_size
- mem_addr  out  32  mapped physical address
- mem_wdata  out  32  copy of cpu_wdata
- mem_addr_ok  in  1  request accepted this cycle
- mem_data_ok  in  1  read data returned / write done this cycle
- mem_rdata  in  32  read data, valid with mem_data_ok

Behaviour:
- FSM states: IDLE, ADDR, DATA, HOLD.
- Reset: state = IDLE, rdata_buf = 0.
  - While rst is high: mem_req = 0, cpu_stall = 0, cpu_rdata = 0.
  - Reset mid-transaction discards the transaction; the downstream shares rst.
- mem_req = (IDLE & cpu_en) | ADDR.
- mem_wr = |cpu_wen. mem_addr, mem_wdata and mem_size are combinational from the cpu inputs; the core holds them stable while cpu_stall is high.
- IDLE:
  - cpu_en & mem_addr_ok → DATA.
  - cpu_en & ~mem_addr_ok → ADDR.
  - Otherwise stay.
- ADDR: mem_addr_ok → DATA. mem_req must stay high until accepted.
- DATA: on mem_data_ok, latch mem_rdata into rdata_buf (stores latch too; value is don't-care); next state is HOLD if cpu_longest_stall, else IDLE.
- HOLD: no request issued. ~cpu_longest_stall → IDLE. That cycle the pipeline advances, so the same M-stage access is not re-requested.
- cpu_stall = (IDLE & cpu_en) | ADDR | (DATA & ~mem_data_ok). It is 0 in HOLD.
- cpu_rdata = (DATA & mem_data_ok) ? mem_rdata : rdata_buf.
  - Zero-wait completion: the pipeline may advance on the same cycle as data_ok.
- mem_data_ok in IDLE, ADDR or HOLD is a protocol error: ignored, no state change. addr_ok and data_ok for the same transaction never coincide.
- Latency: minimum 2 cycles from cpu_en to stall release (addr_ok in cycle 0, data_ok in cycle 1). There is no upper bound; the block waits indefinitely.
- Back-to-back accesses: after DATA→IDLE, a new cpu_en in the next cycle issues a new request immediately.
- cpu_en = 0 never asserts mem_req or cpu_stall.

Decomposition:
- Shared package (cpu_defs) holds:
  - state encoding typedef (2 bits)
  - size constants SIZE_B/SIZE_H/SIZE_W
  - KSEG0_HI = 3'b100, KSEG1_HI = 3'b101
- One sub-module: kseg_addr_map. It is purely combinational (virtual → physical) and shared with the future instruction-side bridge.

Test Plan:
- Word load, addr 0xBFC0_0010: addr_ok in cycle 0, data_ok with rdata 0xDEADBEEF in cycle 1 → mem_addr = 0x1FC0_0010, mem_wr = 0; cpu_stall high in cycle 0 only; cpu_rdata = 0xDEADBEEF in cycle 1.
- Byte store, wen = 4'b0100, addr 0x8000_0002, addr_ok delayed 3 cycles → mem_req high for 4 cycles with stable fields, mem_size = 0, mem_wr = 1; cpu_stall drops on the data_ok cycle.
- Load completes while cpu_longest_stall is held 4 more cycles → HOLD; mem_req stays 0; cpu_rdata holds the buffered value; exactly one request is counted.
- Two consecutive loads with no gap → two distinct requests; the second is issued the cycle after the first data_ok.
- rst asserted while in DATA → next cycle IDLE; cpu_stall = 0, cpu_rdata = 0; a later load proceeds normally.
- MAP_KSEG = 0, addr 0xA000_0000 → mem_addr = 0xA000_0000.
